// File: rtl/jk_counter_pkg.sv
// Shared mode encoding and J/K excitation helper
// for the JK-stage modulo counter.
package jk_counter_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOLD = 2'b00;
   localparam mode_t MODE_UP   = 2'b01;
   localparam mode_t MODE_DOWN = 2'b10;
   localparam mode_t MODE_LOAD = 2'b11;

   // Returns {j, k} for one stage given the resolved mode,
   // the lower-bit AND terms for each direction, and the
   // load data bit for this stage.
   function automatic logic [1:0] excite(
      input mode_t mode,
      input logic  up_and,
      input logic  dn_and,
      input logic  d
   );
      logic [1:0] jk;
      jk = 2'b00;
      case (mode)
         MODE_UP:   jk = {up_and, up_and};
         MODE_DOWN: jk = {dn_and, dn_and};
         MODE_LOAD: jk = {d, ~d};
         default:   jk = 2'b00;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_counter_stage.sv
// Single JK flip-flop with synchronous
// active-high reset.
module jk_stage (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   // JK characteristic: hold, reset, set, toggle
   always_ff @(posedge clk) begin
      if (reset) q <= 1'b0;
      else       q <= (j & ~q) | (~k & q);
   end

endmodule

// File: rtl/jk_mux_excite_counter.sv
// Modulo-MOD up/down counter built from JK stages,
// with a mode mux generating the J/K excitation.
module jk_mux_excite_counter
   import jk_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             load_err,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k
);

   localparam logic [WIDTH-1:0] MAX   = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] dn_t;
   mode_t            mode_req;
   mode_t            mode;
   logic             at_max;
   logic             at_zero;
   logic             illegal;
   logic             lv_bad;

   assign count   = q;
   assign at_max  = (q == MAX);
   assign at_zero = (q == '0);
   assign illegal = ({1'b0, q} >= MOD_X);
   assign lv_bad  = ({1'b0, load_val} >= MOD_X);

   assign tc = en & ~load &
               ((up_dn & at_max) | (~up_dn & at_zero));

   // Resolve mode, fold wrap into the load path,
   // and drive the per-stage excitation mux.
   always_comb begin
      mode_req = MODE_HOLD;
      if (load)       mode_req = MODE_LOAD;
      else if (en)    mode_req = up_dn ? MODE_UP : MODE_DOWN;

      up_t[0] = 1'b1;
      dn_t[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         up_t[i] = up_t[i-1] & q[i-1];
         dn_t[i] = dn_t[i-1] & ~q[i-1];
      end

      mode = mode_req;
      d    = '0;
      case (mode_req)
         MODE_LOAD: d = lv_bad ? MAX : load_val;
         MODE_UP: begin
            if (at_max | illegal) mode = MODE_LOAD;
         end
         MODE_DOWN: begin
            if (illegal) begin
               mode = MODE_LOAD;
            end else if (at_zero) begin
               mode = MODE_LOAD;
               d    = MAX;
            end
         end
         default: mode = MODE_HOLD;
      endcase

      for (int i = 0; i < WIDTH; i++) begin
         {jk_j[i], jk_k[i]} = excite(mode, up_t[i], dn_t[i], d[i]);
      end
   end

   // Flag a saturated load for the following cycle only
   always_ff @(posedge clk) begin
      if (reset) load_err <= 1'b0;
      else       load_err <= load & lv_bad;
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_stage
      jk_stage u_stage (
         .clk   (clk),
         .reset (reset),
         .j     (jk_j[g]),
         .k     (jk_k[g]),
         .q     (q[g])
      );
   end

endmodule

// File: tb/tb_jk_mux_excite_counter.sv
// Self-checking bench: vector table, directed corner
// sequences and randomized run against a value model.
module tb_jk_mux_excite_counter;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic         clk;
   logic         reset;
   logic         en;
   logic         up_dn;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         tc;
   logic         load_err;
   logic [W-1:0] jk_j;
   logic [W-1:0] jk_k;

   int checks = 0;
   int errors = 0;

   int m_count = 0;
   int m_err   = 0;

   jk_mux_excite_counter #(.WIDTH(W), .MOD(MOD)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .load_err (load_err),
      .jk_j     (jk_j),
      .jk_k     (jk_k)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit r;
      bit e;
      bit u;
      bit l;
      int lv;
      int cnt;
      bit tcx;
      bit err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Next value from the counting rules, in plain arithmetic
   function automatic int model_next(input int c, input bit r,
         input bit e, input bit u, input bit l, input int lv);
      if (r) return 0;
      if (l) return (lv < MOD) ? lv : MOD - 1;
      if (!e) return c;
      if (u) return (c >= MOD - 1) ? 0 : c + 1;
      if (c >= MOD) return 0;
      return (c == 0) ? MOD - 1 : c - 1;
   endfunction

   task automatic step(input bit r, input bit e, input bit u,
         input bit l, input int lv, output bit tc_seen);
      int  n;
      bit  ld_type;
      int  ej;
      int  ek;
      bit  etc;
      reset    = r;
      en       = e;
      up_dn    = u;
      load     = l;
      load_val = W'(lv);
      #1;
      n   = model_next(m_count, 1'b0, e, u, l, lv);
      etc = e && !l && ((u && m_count == MOD - 1) ||
                        (!u && m_count == 0));
      chk("tc", int'(tc), int'(etc));
      tc_seen = tc;
      if (!r) begin
         ld_type = l || (e && u && m_count >= MOD - 1) ||
                   (e && !u && (m_count == 0 || m_count >= MOD));
         if (!l && !e) begin
            ej = 0;
            ek = 0;
         end else if (ld_type) begin
            ej = n;
            ek = (~n) & ((1 << W) - 1);
         end else begin
            ej = m_count ^ n;
            ek = m_count ^ n;
         end
         chk("jk_j", int'(jk_j), ej);
         chk("jk_k", int'(jk_k), ek);
      end
      @(posedge clk);
      #1;
      m_count = model_next(m_count, r, e, u, l, lv);
      m_err   = (!r && l && lv >= MOD) ? 1 : 0;
      chk("count", int'(count), m_count);
      chk("load_err", int'(load_err), m_err);
   endtask

   function automatic vec_t mk(input bit r, input bit e,
         input bit u, input bit l, input int lv, input int cnt,
         input bit tcx, input bit err);
      vec_t v;
      v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv;
      v.cnt = cnt; v.tcx = tcx; v.err = err;
      return v;
   endfunction

   initial begin
      bit t;
      reset = 1'b1;
      en = 1'b0;
      up_dn = 1'b0;
      load = 1'b0;
      load_val = '0;

      // Reset, count up 12 cycles with wrap
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 12; i++)
         vecs.push_back(mk(0, 1, 1, 0, 0, (i + 1) % MOD,
                           (i == 9), 0));
      // Reset, count down through 0 wrap
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 9, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 7, 0, 0));
      // Legal load then up through wrap
      vecs.push_back(mk(0, 0, 0, 1, 7, 7, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 8, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
      // Out-of-range loads saturate, flag one cycle
      vecs.push_back(mk(0, 0, 0, 1, 12, 9, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 3, 3, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 15, 9, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 9, 9, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 10, 9, 0, 1));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));

      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l,
              vecs[i].lv, t);
         chk("vec_tc", int'(t), int'(vecs[i].tcx));
         chk("vec_count", int'(count), vecs[i].cnt);
         chk("vec_err", int'(load_err), int'(vecs[i].err));
      end

      // Excitation at count 7 going up, and at 0 going down
      step(0, 0, 0, 1, 7, t);
      reset = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0;
      #1;
      chk("jk_j_at7", int'(jk_j), 15);
      chk("jk_k_at7", int'(jk_k), 15);
      step(1, 0, 0, 0, 0, t);
      reset = 1'b0; en = 1'b1; up_dn = 1'b0; load = 1'b0;
      #1;
      chk("jk_j_at0dn", int'(jk_j), 9);
      chk("jk_k_at0dn", int'(jk_k), 6);
      chk("tc_at0dn", int'(tc), 1);

      // Count to 5, hold 4 cycles, then resume
      step(1, 0, 0, 0, 0, t);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, t);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 0, t);
         chk("hold_count", int'(count), 5);
         chk("hold_jk", int'({jk_j, jk_k}), 0);
         chk("hold_tc", int'(t), 0);
      end
      step(0, 1, 1, 0, 0, t);
      chk("resume_count", int'(count), 6);

      // Reset wins over a concurrent load
      step(0, 1, 1, 1, 12, t);
      step(1, 1, 1, 1, 3, t);
      chk("rst_count", int'(count), 0);
      chk("rst_err", int'(load_err), 0);
      step(0, 1, 1, 0, 0, t);
      chk("after_rst1", int'(count), 1);
      step(0, 1, 1, 0, 0, t);
      chk("after_rst2", int'(count), 2);

      // Randomized run against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 15)), t);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_mux_excite_counter.md
Name: jk_mux_excite_counter

Overview:
- Synchronous modulo-N up/down counter built from per-bit JK flip-flop stages.
- The J/K excitation of each stage is produced by a 4:1 multiplexer selected by the operating mode: hold, up, down or load.
- Sits directly upstream of the JK flip-flop stages: it generates their J/K inputs, consumes their Q outputs, and wraps them into a complete counter.
- Feeds count value and terminal-count flag to downstream display/cascade logic.

Parameters:
- WIDTH, 4, number of counter bits / JK stages.
- MOD, 10, counting modulus; legal count range 0..MOD-1; 2 <= MOD <= 2**WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising clk.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel-load request.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current counter state (Q of the JK stages).
- tc  output  1  terminal count, combinational from state and inputs.
- load_err  output  1  registered; out-of-range load occurred last cycle.
- jk_j  output  WIDTH  per-stage J excitation (observability).
- jk_k  output  WIDTH  per-stage K excitation (observability).

Behaviour:
- One clock; reset is synchronous and active-high (port names clk, reset).
- Reset: count=0 and load_err=0 on the clk edge where reset=1.
- Priority: reset > load > en > hold.
- Mode select:
  - LOAD if load=1.
  - else UP if en&up_dn.
  - else DOWN if en&~up_dn.
  - else HOLD.
- Excitation mux per bit i:
  - HOLD: J=0, K=0.
  - UP: J=K=AND(count[i-1:0]); bit 0 is J=K=1.
  - DOWN: J=K=AND(~count[i-1:0]); bit 0 is J=K=1.
  - LOAD: J=d[i], K=~d[i], where d is the effective load value.
- Wrap: modulus wrap is done through the load path, never by a separate register write.
  - UP with count==MOD-1: the mux forces LOAD with d=0.
  - DOWN with count==0: the mux forces LOAD with d=MOD-1.
- Latency: count updates on the same edge the mode is sampled, one cycle from input to count.
- Load range:
  - load_val < MOD: d=load_val, load_err=0 next cycle.
  - load_val >= MOD: d=MOD-1 (saturate), load_err=1 for exactly one cycle.
  - Any non-load cycle clears load_err.
- tc = en & ~load & ((up_dn & count==MOD-1) | (~up_dn & count==0)).
  - After reset with en=1 and up_dn=0, tc=1 immediately.
- Illegal state: if count >= MOD (only reachable through X/forced state), the next UP or DOWN cycle loads 0.
- Reset mid-operation: the count aborts to 0 on that edge regardless of load/en; load_err=0.
- Direction change takes effect on the next edge with no extra cycle.
- jk_j/jk_k reflect the mux output for the current cycle; under reset the values are don't-care.

Decomposition:
- Shared package jk_counter_pkg:
  - 2-bit mode constants MODE_HOLD=00, MODE_UP=01, MODE_DOWN=10, MODE_LOAD=11.
  - Mode typedef.
  - Helper function computing the per-bit excitation from mode, lower-bit AND terms and d.
- One sub-module jk_stage: a single JK flip-flop with synchronous active-high reset, ports clk, reset, j, k, q. It is instantiated WIDTH times via generate.
- Mux/wrap/tc logic stays in the top module.

Test Plan:
- Reset, then en=1, up_dn=1 for 12 cycles -> count 0,1,...,9,0,1; tc=1 only while count=9; jk_j=jk_k=4'b1111 at count=7.
- Reset, then en=1, up_dn=0 -> count 0,9,8,7; tc=1 at count=0; at count=0 jk_j=4'b1001, jk_k=4'b0110 (load 9).
- load=1, load_val=7, then en=1, up_dn=1 for 3 cycles -> count 7,8,9,0; load_err stays 0.
- load=1, load_val=12 -> count=9, load_err=1 for one cycle, then 0; load=1 with en=1 same cycle -> load wins.
- Count up to 5, drop en for 4 cycles, then raise en -> count holds 5 with jk_j=jk_k=0 and tc=0, then resumes at 6.
- Count to 6, assert reset for one cycle while load=1, load_val=3 -> count=0 and load_err=0 next cycle; counting resumes 1,2.
